// File: rtl/config_scan_loader.sv
// Byte-fed scan-chain loader: accepts bytes, shifts CHAIN_LEN bits LSB-first into a scan chain.
// Optional readback of the chain's previous content is built when CFG_READBACK_EN is defined.
module config_scan_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       scan_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       scan_en,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
`ifdef CFG_READBACK_EN
  ,
  output logic [7:0] rb_data,
  output logic       rb_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       shreg_q;
  logic             in_ready_q;
  logic             scan_en_q;
  logic             scan_in_q;
  logic             busy_q;
  logic             done_q;
  logic             last_bit;
  logic             byte_end;

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    last_bit = (cnt_d == CNT_W'(CHAIN_LEN));
    byte_end = (cnt_d[2:0] == 3'd0);
  end

  // Outputs are registered, so each transition also sets the outputs of the state being entered.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      in_ready_q <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            state_q    <= S_SHIFT;
            shreg_q    <= in_data;
            in_ready_q <= 1'b0;
            scan_en_q  <= 1'b1;
            scan_in_q  <= in_data[0];
          end
        end
        S_SHIFT: begin
          shreg_q <= {1'b0, shreg_q[7:1]};
          cnt_q   <= cnt_d;
          if (last_bit) begin
            state_q   <= S_DONE;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (byte_end) begin
            state_q    <= S_LOAD;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            scan_in_q <= shreg_q[1];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          scan_en_q  <= 1'b0;
          scan_in_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign scan_en  = scan_en_q;
  assign scan_in  = scan_in_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef CFG_READBACK_EN
  logic [7:0] rb_acc_q;
  logic [7:0] rb_acc_d;
  logic [7:0] rb_data_q;
  logic       rb_valid_q;

  // Each sampled tail bit lands at its position within the current byte, so partial bytes stay low-aligned.
  always_comb begin
    rb_acc_d              = rb_acc_q;
    rb_acc_d[cnt_q[2:0]]  = scan_out;
  end

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (state_q == S_SHIFT) begin
        if (last_bit || byte_end) begin
          rb_data_q  <= rb_acc_d;
          rb_valid_q <= 1'b1;
          rb_acc_q   <= '0;
        end else begin
          rb_acc_q <= rb_acc_d;
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
`endif

endmodule

// File: tb/tb_config_scan_loader.sv
// Directed bench for config_scan_loader: two instances (16-bit and 12-bit chains) with behavioural chain models.
module tb_config_scan_loader;

  logic        clk;
  logic        rst;
  logic        start16, in_valid16, in_ready16, scan_en16, scan_in16, busy16, done16;
  logic        start12, in_valid12, in_ready12, scan_en12, scan_in12, busy12, done12;
  logic [7:0]  in_data16, in_data12;
  logic [15:0] chain16, pv16;
  logic [11:0] chain12, pv12;
  logic        ld16, ld12;
`ifdef CFG_READBACK_EN
  logic [7:0]  rbd16, rbd12;
  logic        rbv16, rbv12;
`endif

  int passed = 0;
  int total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  config_scan_loader #(.CHAIN_LEN(16), .CNT_W(16)) d16 (
    .scan_clk(clk), .rst(rst), .start(start16), .in_data(in_data16), .in_valid(in_valid16),
    .in_ready(in_ready16), .scan_en(scan_en16), .scan_in(scan_in16), .scan_out(chain16[0]),
    .busy(busy16), .done(done16)
`ifdef CFG_READBACK_EN
    , .rb_data(rbd16), .rb_valid(rbv16)
`endif
  );

  config_scan_loader #(.CHAIN_LEN(12), .CNT_W(16)) d12 (
    .scan_clk(clk), .rst(rst), .start(start12), .in_data(in_data12), .in_valid(in_valid12),
    .in_ready(in_ready12), .scan_en(scan_en12), .scan_in(scan_in12), .scan_out(chain12[0]),
    .busy(busy12), .done(done12)
`ifdef CFG_READBACK_EN
    , .rb_data(rbd12), .rb_valid(rbv12)
`endif
  );

  // Chain models: index 0 is the tail, the head receives scan_in.
  always @(posedge clk) begin
    if (ld16) chain16 <= pv16;
    else if (scan_en16) chain16 <= {scan_in16, chain16[15:1]};
    if (ld12) chain12 <= pv12;
    else if (scan_en12) chain12 <= {scan_in12, chain12[11:1]};
  end

  task automatic set_in(input bit sel, input logic st, input logic v, input logic [7:0] d);
    if (sel) begin start12 = st; in_valid12 = v; in_data12 = d; end
    else begin start16 = st; in_valid16 = v; in_data16 = d; end
  endtask

  task automatic preload(input bit sel, input logic [15:0] v);
    if (sel) begin ld12 = 1'b1; pv12 = v[11:0]; end
    else begin ld16 = 1'b1; pv16 = v; end
    @(negedge clk);
    ld12 = 1'b0;
    ld16 = 1'b0;
  endtask

  // Runs one load: start + byte feed, optional 5-cycle style gap, start pulse or reset injection mid-shift.
  task automatic drive_load(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                            input int gap, input int start_at, input int rst_at,
                            output logic [15:0] seq, output int nbits, output int ndone,
                            output int lat, output int gap_bad, output logic [2:0] post_rst,
                            output bit timeout, output logic [7:0] rb0, output logic [7:0] rb1,
                            output int nrb, output int rb_at0, output int rb_at1);
    int idx, first_busy, gap_left;
    bit pending, gap_used, rst_pend;
    logic o_busy, o_ready, o_en, o_in, o_done, st_v, val_v;
    logic [7:0] dat_v;
    seq = '0; nbits = 0; ndone = 0; lat = -1; gap_bad = 0; post_rst = '0; timeout = 1'b1;
    rb0 = '0; rb1 = '0; nrb = 0; rb_at0 = -1; rb_at1 = -1;
    idx = 0; first_busy = -1; gap_left = 0; pending = 1'b0; gap_used = 1'b0; rst_pend = 1'b0;
    set_in(sel, 1'b1, 1'b1, b0);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      if (sel) {o_busy, o_ready, o_en, o_in, o_done} = {busy12, in_ready12, scan_en12, scan_in12, done12};
      else     {o_busy, o_ready, o_en, o_in, o_done} = {busy16, in_ready16, scan_en16, scan_in16, done16};
`ifdef CFG_READBACK_EN
      if (!sel && rbv16) begin
        if (nrb == 0) begin rb0 = rbd16; rb_at0 = nbits; end
        else if (nrb == 1) begin rb1 = rbd16; rb_at1 = nbits; end
        nrb++;
      end
`endif
      if (rst_pend) begin
        post_rst = {o_busy, o_en, o_done};
        rst = 1'b0;
        timeout = 1'b0;
        break;
      end
      if (o_en) begin
        if (nbits < 16) seq[nbits] = o_in;
        nbits++;
      end
      if (o_done) begin ndone++; lat = cyc - first_busy + 1; end
      if (o_busy && first_busy < 0) first_busy = cyc;
      if (ndone > 0 && !o_busy) begin timeout = 1'b0; break; end
      if (pending) idx++;
      st_v = (start_at > 0 && o_en && nbits == start_at);
      if (rst_at > 0 && o_en && nbits == rst_at) begin rst = 1'b1; rst_pend = 1'b1; end
      if (!gap_used && gap > 0 && idx == 1 && o_ready) begin gap_left = gap; gap_used = 1'b1; end
      if (gap_left > 0) begin
        val_v = 1'b0;
        if (!(o_ready && !o_en)) gap_bad++;
        gap_left--;
      end else begin
        val_v = 1'b1;
      end
      dat_v = (idx == 0) ? b0 : (idx == 1) ? b1 : 8'h00;
      set_in(sel, st_v, val_v, dat_v);
      pending = o_ready && val_v;
    end
    set_in(sel, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy16, done16, in_ready16, scan_en16, scan_in16} !== 5'b0) begin
      $display("FAIL reset16 got=%b exp=00000", {busy16, done16, in_ready16, scan_en16, scan_in16});
    end else passed++;
    total++;
    if ({busy12, done12, in_ready12, scan_en12, scan_in12} !== 5'b0) begin
      $display("FAIL reset12 got=%b exp=00000", {busy12, done12, in_ready12, scan_en12, scan_in12});
    end else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load16;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b0, 16'hFFFF);
    drive_load(1'b0, 8'hA5, 8'h3C, 0, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (to !== 1'b0) $display("FAIL load16_timeout got=%0d exp=0", to); else passed++;
    total++; if (seq !== 16'h3CA5) $display("FAIL load16_seq got=%h exp=3ca5", seq); else passed++;
    total++; if (nb !== 16) $display("FAIL load16_nbits got=%0d exp=16", nb); else passed++;
    total++; if (nd !== 1) $display("FAIL load16_done got=%0d exp=1", nd); else passed++;
    total++; if (lat !== 19) $display("FAIL load16_latency got=%0d exp=19", lat); else passed++;
    total++; if (chain16 !== 16'h3CA5) $display("FAIL load16_chain got=%h exp=3ca5", chain16); else passed++;
  endtask

  task automatic test_partial12;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b1, 16'h0000);
    drive_load(1'b1, 8'hFF, 8'h0F, 0, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (nb !== 12) $display("FAIL p12_nbits got=%0d exp=12", nb); else passed++;
    total++; if (seq[11:8] !== 4'hF) $display("FAIL p12_last4 got=%h exp=f", seq[11:8]); else passed++;
    total++; if (nd !== 1) $display("FAIL p12_done got=%0d exp=1", nd); else passed++;
    total++; if (lat !== 15) $display("FAIL p12_latency got=%0d exp=15", lat); else passed++;
    preload(1'b1, 16'h0000);
    drive_load(1'b1, 8'h5A, 8'hC3, 0, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (seq[11:0] !== 12'h35A) $display("FAIL p12_seq got=%h exp=35a", seq[11:0]); else passed++;
    total++; if (chain12 !== 12'h35A) $display("FAIL p12_chain got=%h exp=35a", chain12); else passed++;
    total++; if (nb !== 12) $display("FAIL p12_nbits2 got=%0d exp=12", nb); else passed++;
  endtask

  task automatic test_gap;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b0, 16'h0000);
    drive_load(1'b0, 8'hA5, 8'h3C, 5, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (gb !== 0) $display("FAIL gap_ready_en got=%0d bad cycles exp=0", gb); else passed++;
    total++; if (seq !== 16'h3CA5) $display("FAIL gap_seq got=%h exp=3ca5", seq); else passed++;
    total++; if (lat !== 24) $display("FAIL gap_latency got=%0d exp=24", lat); else passed++;
    total++; if (nd !== 1) $display("FAIL gap_done got=%0d exp=1", nd); else passed++;
  endtask

  task automatic test_reset_mid_shift;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b0, 16'h0000);
    drive_load(1'b0, 8'hA5, 8'h3C, 0, 0, 5, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (to !== 1'b0) $display("FAIL rst_timeout got=%0d exp=0", to); else passed++;
    total++; if (pr !== 3'b000) $display("FAIL rst_busy_en_done got=%b exp=000", pr); else passed++;
    total++; if (nd !== 0) $display("FAIL rst_no_done got=%0d exp=0", nd); else passed++;
    total++; if (chain16 !== 16'h2800) $display("FAIL rst_partial_chain got=%h exp=2800", chain16); else passed++;
    repeat (3) @(negedge clk);
    total++; if (busy16 !== 1'b0) $display("FAIL rst_idle got=%b exp=0", busy16); else passed++;
    preload(1'b0, 16'h0000);
    drive_load(1'b0, 8'h3C, 8'hA5, 0, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (seq !== 16'hA53C) $display("FAIL reload_seq got=%h exp=a53c", seq); else passed++;
    total++; if (chain16 !== 16'hA53C) $display("FAIL reload_chain got=%h exp=a53c", chain16); else passed++;
    total++; if (lat !== 19) $display("FAIL reload_latency got=%0d exp=19", lat); else passed++;
  endtask

  task automatic test_start_while_busy;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b0, 16'h0000);
    drive_load(1'b0, 8'h81, 8'h7E, 0, 3, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (nb !== 16) $display("FAIL sbusy_nbits got=%0d exp=16", nb); else passed++;
    total++; if (nd !== 1) $display("FAIL sbusy_done got=%0d exp=1", nd); else passed++;
    total++; if (seq !== 16'h7E81) $display("FAIL sbusy_seq got=%h exp=7e81", seq); else passed++;
    repeat (4) @(negedge clk);
    total++; if (busy16 !== 1'b0) $display("FAIL sbusy_no_requeue got=%b exp=0", busy16); else passed++;
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback;
    logic [15:0] seq; int nb, nd, lat, gb, nr, a0, a1; logic [2:0] pr; bit to; logic [7:0] r0, r1;
    preload(1'b0, 16'h1234);
    drive_load(1'b0, 8'h00, 8'h00, 0, 0, 0, seq, nb, nd, lat, gb, pr, to, r0, r1, nr, a0, a1);
    total++; if (nr !== 2) $display("FAIL rb_count got=%0d exp=2", nr); else passed++;
    total++; if (r0 !== 8'h34) $display("FAIL rb_byte0 got=%h exp=34", r0); else passed++;
    total++; if (r1 !== 8'h12) $display("FAIL rb_byte1 got=%h exp=12", r1); else passed++;
    total++; if (a0 !== 8) $display("FAIL rb_time0 got=%0d exp=8", a0); else passed++;
    total++; if (a1 !== 16) $display("FAIL rb_time1 got=%0d exp=16", a1); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; ld16 = 1'b0; ld12 = 1'b0; pv16 = '0; pv12 = '0;
    start16 = 1'b0; in_valid16 = 1'b0; in_data16 = '0;
    start12 = 1'b0; in_valid12 = 1'b0; in_data12 = '0;
    @(negedge clk);
    test_reset();
    test_load16();
    test_partial12();
    test_gap();
    test_reset_mid_shift();
    test_start_while_busy();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
